// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared constants and fetch FSM encoding for the CPU pipe front end
package cpu_pipe_pkg;

  // Fetch PC after reset when the top is not overridden
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction word presented to decode when no entry is valid
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // One IF/ID entry is {pc+4, instr}
  localparam int ENTRY_W = 64;

  // Fetch FSM encoding
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_REQ  = 2'd1;
  localparam fetch_state_t ST_DROP = 2'd2;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH x 64-bit synchronous prefetch queue with flush
module fetch_fifo
  import cpu_pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [ENTRY_W-1:0]         head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               full;
  logic               do_pop;
  logic               do_push;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop is only honoured with data present; a push into a full queue is
  // allowed only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking; flush wins over push and pop
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because empty entries are never shown
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];

  // Occupancy can never exceed the number of entries
  assert property (@(posedge clk_i) disable iff (!rst_n) count <= CW'(DEPTH));

endmodule

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - instruction fetch front end with prefetch queue and redirect flush
module if_prefetch_unit
  import cpu_pipe_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t       state_q;
  fetch_state_t       state_d;
  logic [31:0]        fetch_pc_q;
  logic [31:0]        fetch_pc_d;
  logic [31:0]        drop_addr_q;
  logic [31:0]        redirect_target;
  logic [31:0]        pc_next;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_after;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head_data;
  logic               push;
  logic               pop;
  logic               idle_credit;
  logic               req_credit;
  logic               unused_pc_bits;

  // Targets are forced word aligned; the low bits carry no information
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_bits  = ^redirect_pc_i[1:0];

  // Natural 32-bit wrap makes 0xFFFFFFFC + 4 = 0
  assign pc_next = fetch_pc_q + 32'd4;

  // A redirect discards in-flight data and blocks the consumer in the same cycle
  assign push = (state_q == ST_REQ) && imem_ack_i && !redirect_i;
  assign pop  = !fifo_empty && !stall_i && !redirect_i;

  assign count_after = count + CW'(push) - CW'(pop);

  // IDLE has nothing outstanding, so pre-edge occupancy is the whole budget.
  // After an ack the slot it held is now counted in the queue itself.
  assign idle_credit = (count < CW'(DEPTH));
  assign req_credit  = (count_after < CW'(DEPTH));

  // Next-state and fetch PC selection
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_target;
        end else if (idle_credit) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_target;
          state_d    = imem_ack_i ? ST_IDLE : ST_DROP;
        end else if (imem_ack_i) begin
          fetch_pc_d = pc_next;
          state_d    = req_credit ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_target;
        end
        if (imem_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and fetch PC registers
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Remember the abandoned address so the memory sees a stable request until it acks
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      drop_addr_q <= RESET_PC;
    end else if ((state_q == ST_REQ) && redirect_i && !imem_ack_i) begin
      drop_addr_q <= fetch_pc_q;
    end
  end

  assign imem_req_o  = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pc_next, imem_data_i}),
    .pop       (pop),
    .flush     (redirect_i),
    .head_data (head_data),
    .count     (count),
    .empty     (fifo_empty)
  );

  assign valid_o    = !fifo_empty;
  assign pc_plus4_o = valid_o ? head_data[ENTRY_W-1:32] : 32'h0;
  assign instr_o    = valid_o ? head_data[31:0] : NOP_INSTR;

endmodule
